// File: rtl/fetch_stage.sv
// Purpose : instruction fetch register stage; reads ROM[prog_ctr] and registers it for decode.
// Latency : one cycle from prog_ctr to instr/instr_pc; done rises one edge after HALT sits in decode.
// Backpress: stall holds the stage (absjump_en overrides it); ROM writes are never blocked.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   prog_ctr          current PC, used as ROM read address
//   absjump_en        jump taken this cycle; the word fetched now is wrong-path
//   stall             decode stall; hold stage contents
//   prog_we/_waddr/_wdata  program load port into the instruction ROM
//   instr, instr_pc   registered instruction and its PC
//   instr_valid       instr is a real, on-path instruction
//   done              sticky, set once a HALT reaches decode
//   fetch_count       number of valid instructions delivered, saturating
module fetch_stage #(
    parameter int             D    = 12,
    parameter int             W    = 9,
    parameter logic [W-1:0]   HALT = 9'h1FF,
    parameter int             CW   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [D-1:0]  prog_ctr,
    input  logic          absjump_en,
    input  logic          stall,
    input  logic          prog_we,
    input  logic [D-1:0]  prog_waddr,
    input  logic [W-1:0]  prog_wdata,
    output logic [W-1:0]  instr,
    output logic [D-1:0]  instr_pc,
    output logic          instr_valid,
    output logic          done,
    output logic [CW-1:0] fetch_count
);

    typedef enum logic [1:0] {
        S_EMPTY  = 2'b00,
        S_VALID  = 2'b01,
        S_HALTED = 2'b10
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    // Instruction ROM: loadable at any time, deliberately not reset so a
    // program survives a stage reset.
    logic [W-1:0] mem [0:(1<<D)-1];
    logic [W-1:0] rom_rdat;
    state_t       state;

    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_waddr] <= prog_wdata;
        end
    end

    // Read is sampled at the same edge as any write, so a same-address
    // read-during-write returns the old word.
    assign rom_rdat = mem[prog_ctr];

    // State is one-hot over instr_valid/done, so both outputs come straight
    // from state flops.
    assign instr_valid = state[0];
    assign done        = state[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_EMPTY;
            instr       <= '0;
            instr_pc    <= '0;
            fetch_count <= '0;
        end else begin
            case (state)
                S_HALTED: begin
                    // Frozen until reset; instr/instr_pc keep the HALT word.
                    state <= S_HALTED;
                end
                default: begin
                    if (state == S_VALID && instr == HALT && !stall) begin
                        // HALT accepted by decode; nothing further is fetched.
                        state <= S_HALTED;
                    end else if (absjump_en) begin
                        // Word at prog_ctr is wrong-path: load it as a bubble.
                        instr    <= rom_rdat;
                        instr_pc <= prog_ctr;
                        state    <= S_EMPTY;
                    end else if (stall) begin
                        state <= state;
                    end else begin
                        instr    <= rom_rdat;
                        instr_pc <= prog_ctr;
                        state    <= S_VALID;
                        if (fetch_count != CNT_MAX) begin
                            fetch_count <= fetch_count + CNT_ONE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int D  = 12;
    localparam int W  = 9;
    localparam int CW = 4;
    localparam int DEPTH = 1 << D;
    localparam int CMAX  = (1 << CW) - 1;
    localparam logic [W-1:0] HALT_W = 9'h1FF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [D-1:0]  prog_ctr = '0;
    logic          absjump_en = 1'b0;
    logic          stall = 1'b0;
    logic          prog_we = 1'b0;
    logic [D-1:0]  prog_waddr = '0;
    logic [W-1:0]  prog_wdata = '0;
    logic [W-1:0]  instr;
    logic [D-1:0]  instr_pc;
    logic          instr_valid;
    logic          done;
    logic [CW-1:0] fetch_count;

    fetch_stage #(.D(D), .W(W), .HALT(HALT_W), .CW(CW)) dut (
        .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .absjump_en(absjump_en),
        .stall(stall), .prog_we(prog_we), .prog_waddr(prog_waddr), .prog_wdata(prog_wdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .done(done),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: program memory plus the architecturally visible stage.
    logic [W-1:0] rom [DEPTH];
    logic [W-1:0] m_instr;
    int           m_pc;
    bit           m_valid;
    bit           m_done;
    int           m_cnt;

    typedef struct {
        int pc; bit jmp; bit stl; bit we; int wa; int wd;
        int e_instr; int e_pc; bit e_valid; bit e_done; int e_cnt;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_instr = '0; m_pc = 0; m_valid = 0; m_done = 0; m_cnt = 0;
    endtask

    // Applies the stage rules for one edge, highest priority first.
    task automatic model_step(input int pc, input bit jmp, input bit stl,
                              input bit we, input int wa, input int wd);
        logic [W-1:0] word;
        word = rom[pc];
        if (m_done) begin
        end else if (m_valid && m_instr == HALT_W && !stl) begin
            m_done = 1; m_valid = 0;
        end else if (jmp) begin
            m_instr = word; m_pc = pc; m_valid = 0;
        end else if (stl) begin
        end else begin
            m_instr = word; m_pc = pc; m_valid = 1;
            if (m_cnt < CMAX) m_cnt++;
        end
        if (we) rom[wa] = W'(wd);
    endtask

    // Drive one edge's inputs, advance the model, sample #1 after the edge.
    task automatic cycle(input int pc, input bit jmp, input bit stl,
                         input bit we, input int wa, input int wd);
        prog_ctr = D'(pc); absjump_en = jmp; stall = stl;
        prog_we = we; prog_waddr = D'(wa); prog_wdata = W'(wd);
        model_step(pc, jmp, stl, we, wa, wd);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".instr"},    32'(instr),       32'(m_instr));
        chk({tag, ".pc"},       32'(instr_pc),    32'(m_pc));
        chk({tag, ".valid"},    32'(instr_valid), 32'(m_valid));
        chk({tag, ".done"},     32'(done),        32'(m_done));
        chk({tag, ".count"},    32'(fetch_count), 32'(m_cnt));
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk({tag, ".rst_instr"}, 32'(instr), 32'd0);
        chk({tag, ".rst_pc"},    32'(instr_pc), 32'd0);
        chk({tag, ".rst_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, ".rst_done"},  32'(done), 32'd0);
        chk({tag, ".rst_count"}, 32'(fetch_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input int i);
        string tag;
        tag = $sformatf("vec%0d", i);
        cycle(vt[i].pc, vt[i].jmp, vt[i].stl, vt[i].we, vt[i].wa, vt[i].wd);
        chk({tag, ".instr"}, 32'(instr),       32'(vt[i].e_instr));
        chk({tag, ".pc"},    32'(instr_pc),    32'(vt[i].e_pc));
        chk({tag, ".valid"}, 32'(instr_valid), 32'(vt[i].e_valid));
        chk({tag, ".done"},  32'(done),        32'(vt[i].e_done));
        chk({tag, ".count"}, 32'(fetch_count), 32'(vt[i].e_cnt));
    endtask

    initial begin
        // Vectors: pc, jmp, stl, we, wa, wd | instr, pc, valid, done, count
        vt.push_back('{0,   0, 0, 0, 0,  0,     'h001, 0,    1, 0, 1});
        vt.push_back('{1,   0, 0, 0, 0,  0,     'h002, 1,    1, 0, 2});
        vt.push_back('{2,   0, 0, 0, 0,  0,     'h003, 2,    1, 0, 3});
        vt.push_back('{1,   0, 0, 0, 0,  0,     'h002, 1,    1, 0, 4});
        vt.push_back('{9,   0, 1, 0, 0,  0,     'h002, 1,    1, 0, 4});
        vt.push_back('{9,   0, 1, 0, 0,  0,     'h002, 1,    1, 0, 4});
        vt.push_back('{9,   0, 1, 0, 0,  0,     'h002, 1,    1, 0, 4});
        vt.push_back('{5,   1, 1, 0, 0,  0,     'h055, 5,    0, 0, 4});
        vt.push_back('{101, 0, 0, 0, 0,  0,     'h0AA, 101,  1, 0, 5});
        vt.push_back('{7,   0, 0, 0, 0,  0,     'h1FF, 7,    1, 0, 6});
        vt.push_back('{8,   0, 0, 0, 0,  0,     'h1FF, 7,    0, 1, 6});
        vt.push_back('{3,   0, 0, 1, 30, 'h123, 'h1FF, 7,    0, 1, 6});
        // second segment, after reset: read-during-write, write-while-done, wrap
        vt.push_back('{20,  0, 0, 1, 20, 'h155, 'h033, 20,   1, 0, 1});
        vt.push_back('{20,  0, 0, 0, 0,  0,     'h155, 20,   1, 0, 2});
        vt.push_back('{30,  0, 0, 0, 0,  0,     'h123, 30,   1, 0, 3});
        vt.push_back('{4095,0, 0, 0, 0,  0,     'h0EE, 4095, 1, 0, 4});
        vt.push_back('{0,   0, 0, 0, 0,  0,     'h001, 0,    1, 0, 5});

        // Program load under reset; random words never equal HALT.
        model_reset();
        for (int a = 0; a < DEPTH; a++) begin
            int wd;
            wd = (a < 4) ? a + 1 : (a == 5) ? 'h055 : (a == 7) ? 'h1FF :
                 (a == 20) ? 'h033 : (a == 101) ? 'h0AA : (a == 4095) ? 'h0EE :
                 int'($urandom_range(0, 'h1FE));
            cycle(0, 0, 0, 1, a, wd);
        end
        // The model was stepped during reset; re-zero its stage state.
        model_reset();
        chk("load_rst.valid", 32'(instr_valid), 32'd0);
        chk("load_rst.count", 32'(fetch_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i);

        // HALTED holds for 10 more edges, even with jumps and fetch attempts.
        for (int i = 0; i < 10; i++) begin
            cycle(i, i[0], 0, 0, 0, 0);
            chk_model($sformatf("halt_hold%0d", i));
        end
        chk("halt_hold.done", 32'(done), 32'd1);
        async_reset("halt");

        for (int i = 12; i < vt.size(); i++) run_vec(i);

        // Saturation: 20 valid fetches into a 4-bit counter.
        async_reset("sat");
        for (int i = 0; i < 20; i++) cycle(40 + i, 0, 0, 0, 0, 0);
        chk("sat.count", 32'(fetch_count), 32'(CMAX));
        chk_model("sat");

        // Random traffic against the model, including HALT, writes and resets.
        for (int i = 0; i < 600; i++) begin
            int pc, wa, wd;
            bit jmp, stl, we;
            if ($urandom_range(0, 99) < 2) begin
                async_reset($sformatf("rnd_rst%0d", i));
            end
            pc  = ($urandom_range(0, 9) == 0) ? 7 : int'($urandom_range(0, DEPTH - 1));
            jmp = ($urandom_range(0, 99) < 15);
            stl = ($urandom_range(0, 99) < 25);
            we  = ($urandom_range(0, 99) < 15);
            wa  = ($urandom_range(0, 1) == 0) ? pc : int'($urandom_range(0, DEPTH - 1));
            wd  = ($urandom_range(0, 7) == 0) ? 'h1FF : int'($urandom_range(0, 'h1FF));
            cycle(pc, jmp, stl, we, wa, wd);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
